// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and memory-wait control for a 4-stage in-order pipeline.
// Produces PC/pipeline-register stall, hold and flush controls from branch,
// load-use and data-memory handshake events. Optional build macro
// PIPECTRL_MEM_TIMEOUT_EN adds a bounded memory wait with a sticky error flag.
module pipeline_ctrl #(
  parameter logic [3:0]  LOAD_OP  = 4'hC,
  parameter logic [3:0]  STORE_OP = 4'hD,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ifid_valid,
  input  logic [1:0] ifid_ra,
  input  logic [1:0] ifid_rb,
  input  logic       idex_valid,
  input  logic [3:0] idex_opcode,
  input  logic [1:0] idex_ra,
  input  logic       exmem_valid,
  input  logic [3:0] exmem_opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       hold_idex,
  output logic       hold_exmem,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic       mem_req,
  output logic [1:0] state,
  output logic [7:0] stall_cnt,
  output logic       mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_t;

  state_t state_q;
  state_t state_d;

  logic mem_op;
  logic mem_stall;
  logic load_use;
  logic timeout;

  assign mem_op    = exmem_valid && ((exmem_opcode == LOAD_OP) || (exmem_opcode == STORE_OP));
  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = idex_valid && (idex_opcode == LOAD_OP) && ifid_valid &&
                     ((idex_ra == ifid_ra) || (idex_ra == ifid_rb));
  assign state     = state_q;

`ifdef PIPECTRL_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       mem_err_q;

  // Wait counter: held at zero outside MEM_WAIT so it starts clean on every entry.
  // It reads k-1 during the k-th wait cycle, so the timeout fires on wait cycle TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset || state_q != MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign timeout = (state_q == MEM_WAIT) && !mem_ready && (wait_cnt == 4'(TIMEOUT - 1));

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err_q <= 1'b0;
    end else if (timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register; reset abandons any outstanding memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings recover to RUN.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:      state_d = mem_stall ? MEM_WAIT : RUN;
      MEM_WAIT: state_d = (mem_ready || timeout) ? RUN : MEM_WAIT;
      default:  state_d = RUN;
    endcase
  end

  // Control outputs, priority: reset > timeout > mem_stall > branch > load-use.
  always_comb begin
    mem_req     = (state_q == MEM_WAIT) ? 1'b1 : mem_op;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    hold_idex   = 1'b0;
    hold_exmem  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (reset) begin
      mem_req     = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (timeout) begin
      flush_exmem = 1'b1;
    end else if (mem_stall) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      hold_idex  = 1'b1;
      hold_exmem = 1'b1;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Stall statistics: count cycles the PC is held, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_pc && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
// Expected per-cycle outputs are queued when stimulus is applied and compared
// mid-cycle; the DUT is built with TIMEOUT=4 so the PIPECTRL_MEM_TIMEOUT_EN
// build exercises the timeout path.
module tb_pipeline_ctrl;

  logic       clk;
  logic       reset;
  logic       ifid_valid;
  logic [1:0] ifid_ra;
  logic [1:0] ifid_rb;
  logic       idex_valid;
  logic [3:0] idex_opcode;
  logic [1:0] idex_ra;
  logic       exmem_valid;
  logic [3:0] exmem_opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       stall_pc, stall_ifid, hold_idex, hold_exmem;
  logic       flush_ifid, flush_idex, flush_exmem;
  logic       mem_req;
  logic [1:0] state;
  logic [7:0] stall_cnt;
  logic       mem_err;

  pipeline_ctrl #(
    .LOAD_OP (4'hC),
    .STORE_OP(4'hD),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ifid_valid  (ifid_valid),
    .ifid_ra     (ifid_ra),
    .ifid_rb     (ifid_rb),
    .idex_valid  (idex_valid),
    .idex_opcode (idex_opcode),
    .idex_ra     (idex_ra),
    .exmem_valid (exmem_valid),
    .exmem_opcode(exmem_opcode),
    .branch_taken(branch_taken),
    .mem_ready   (mem_ready),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .hold_idex   (hold_idex),
    .hold_exmem  (hold_exmem),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .flush_exmem (flush_exmem),
    .mem_req     (mem_req),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl order: {stall_pc, stall_ifid, hold_idex, hold_exmem, flush_ifid, flush_idex, flush_exmem}
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_MST  = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_RST  = 7'b0000111;
  localparam logic [6:0] C_TO   = 7'b0000001;

  typedef struct packed {
    logic [6:0] ctl;
    logic       mreq;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_cnt;
  logic       exp_err;

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Queue the expectation for the cycle now being driven, then compare mid-cycle.
  task automatic step(input string tag, input logic [6:0] ctl, input logic mreq, input logic [1:0] st);
    exp_t e;
    e.ctl  = ctl;
    e.mreq = mreq;
    e.st   = st;
    e.cnt  = exp_cnt;
    e.err  = exp_err;
    sb.push_back(e);
    if (reset) begin
      exp_cnt = '0;
      exp_err = 1'b0;
    end else if (ctl[6] && exp_cnt != 8'hFF) begin
      exp_cnt = exp_cnt + 8'd1;
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "ctl", {1'b0, stall_pc, stall_ifid, hold_idex, hold_exmem, flush_ifid, flush_idex, flush_exmem},
          {1'b0, e.ctl});
      chk(tag, "mem_req",   {7'd0, mem_req}, {7'd0, e.mreq});
      chk(tag, "state",     {6'd0, state},   {6'd0, e.st});
      chk(tag, "stall_cnt", stall_cnt,       e.cnt);
      chk(tag, "mem_err",   {7'd0, mem_err}, {7'd0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_valid   = 1'b0;
    ifid_ra      = 2'd0;
    ifid_rb      = 2'd0;
    idex_valid   = 1'b0;
    idex_opcode  = 4'h0;
    idex_ra      = 2'd0;
    exmem_valid  = 1'b0;
    exmem_opcode = 4'h0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = '0;
    exp_err  = 1'b0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and reset-time outputs
    step("reset", C_RST, 1'b0, 2'b00);
    reset = 1'b0;
    step("idle", C_IDLE, 1'b0, 2'b00);

    // Load with three not-ready cycles
    exmem_valid = 1'b1; exmem_opcode = 4'hC; mem_ready = 1'b0;
    step("ld_w1", C_MST, 1'b1, 2'b00);
    step("ld_w2", C_MST, 1'b1, 2'b01);
    step("ld_w3", C_MST, 1'b1, 2'b01);
    mem_ready = 1'b1;
    step("ld_done", C_IDLE, 1'b1, 2'b01);
    exmem_valid = 1'b0; mem_ready = 1'b0;
    step("ld_after", C_IDLE, 1'b0, 2'b00);

    // Store ready immediately: no stall
    exmem_valid = 1'b1; exmem_opcode = 4'hD; mem_ready = 1'b1;
    step("st_zero", C_IDLE, 1'b1, 2'b00);
    // Non-memory opcode never requests
    exmem_opcode = 4'h3; mem_ready = 1'b0;
    step("alu_op", C_IDLE, 1'b0, 2'b00);
    exmem_valid = 1'b0;

    // Load-use hazards
    idex_valid = 1'b1; idex_opcode = 4'hC; idex_ra = 2'd2;
    ifid_valid = 1'b1; ifid_ra = 2'd0; ifid_rb = 2'd2;
    step("lu_rb", C_LU, 1'b0, 2'b00);
    ifid_ra = 2'd1; ifid_rb = 2'd1;
    step("lu_none", C_IDLE, 1'b0, 2'b00);
    ifid_ra = 2'd2; ifid_rb = 2'd3;
    step("lu_ra", C_LU, 1'b0, 2'b00);
    idex_opcode = 4'h5;
    step("lu_notload", C_IDLE, 1'b0, 2'b00);
    idex_opcode = 4'hC; ifid_valid = 1'b0;
    step("lu_ifid_inv", C_IDLE, 1'b0, 2'b00);
    ifid_valid = 1'b1;

    // Branch outranks load-use
    branch_taken = 1'b1;
    step("br_over_lu", C_BR, 1'b0, 2'b00);

    // Memory stall outranks branch; branch takes effect on the ready cycle
    exmem_valid = 1'b1; exmem_opcode = 4'hC; mem_ready = 1'b0;
    step("ms_over_br", C_MST, 1'b1, 2'b00);
    step("br_in_wait", C_MST, 1'b1, 2'b01);
    mem_ready = 1'b1;
    step("br_at_ready", C_BR, 1'b1, 2'b01);
    idle_inputs();
    step("br_after", C_IDLE, 1'b0, 2'b00);

    // Memory never ready
    exmem_valid = 1'b1; exmem_opcode = 4'hC; mem_ready = 1'b0;
    step("to_run", C_MST, 1'b1, 2'b00);
    for (int i = 1; i <= 3; i++) step("to_wait", C_MST, 1'b1, 2'b01);
`ifdef PIPECTRL_MEM_TIMEOUT_EN
    step("to_fire", C_TO, 1'b1, 2'b01);
    exp_err = 1'b1;
    exmem_valid = 1'b0;
    step("to_after", C_IDLE, 1'b0, 2'b00);
`else
    step("to_wait4", C_MST, 1'b1, 2'b01);
    step("to_wait5", C_MST, 1'b1, 2'b01);
    mem_ready = 1'b1;
    step("to_ready", C_IDLE, 1'b1, 2'b01);
    exmem_valid = 1'b0; mem_ready = 1'b0;
    step("to_after", C_IDLE, 1'b0, 2'b00);
`endif

    // Reset in the middle of a memory wait
    exmem_valid = 1'b1; exmem_opcode = 4'hD; mem_ready = 1'b0;
    step("rw_run", C_MST, 1'b1, 2'b00);
    step("rw_wait", C_MST, 1'b1, 2'b01);
    reset = 1'b1;
    step("rw_reset", C_RST, 1'b0, 2'b01);
    reset = 1'b0; exmem_valid = 1'b0;
    step("rw_after", C_IDLE, 1'b0, 2'b00);

    // Counter saturation over a long load-use stall
    idex_valid = 1'b1; idex_opcode = 4'hC; idex_ra = 2'd3;
    ifid_valid = 1'b1; ifid_ra = 2'd3; ifid_rb = 2'd0;
    for (int i = 0; i < 300; i++) step("sat", C_LU, 1'b0, 2'b00);
    idle_inputs();
    step("sat_hold", C_IDLE, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter LOAD_OP, default 4'hC, opcode of memory load.
REQ-002 SHALL have parameter STORE_OP, default 4'hD, opcode of memory store.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum MEM_WAIT cycles (1..15).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports ifid_valid/ifid_ra/ifid_rb  input  1/2/2  decode-stage instruction valid and source registers.
REQ-007 SHALL have ports idex_valid/idex_opcode/idex_ra  input  1/4/2  execute-stage instruction valid, opcode and destination.
REQ-008 SHALL have ports exmem_valid/exmem_opcode  input  1/4  memory-stage instruction valid and opcode.
REQ-009 SHALL have ports branch_taken  input  1 (EX-resolved taken branch) and mem_ready  input  1 (data memory completes access this cycle).
REQ-010 SHALL have outputs stall_pc, stall_ifid, hold_idex, hold_exmem  1 each: hold contents of PC and the respective pipeline registers.
REQ-011 SHALL have outputs flush_ifid, flush_idex, flush_exmem  1 each: insert a bubble into the respective register at the next edge.
REQ-012 SHALL have outputs mem_req  1, state  2 (current FSM state), stall_cnt  8 (stall statistics), mem_err  1 (sticky timeout error).

Function
REQ-013 SHALL implement FSM states RUN=2'b00, MEM_WAIT=2'b01; encodings 2'b10/2'b11 SHALL transition to RUN.
REQ-014 SHALL drive all control outputs combinationally from current state and inputs; state, counters and mem_err SHALL be registered.
REQ-015 mem_op SHALL be exmem_valid and (exmem_opcode==LOAD_OP or exmem_opcode==STORE_OP); mem_req SHALL equal mem_op in RUN and 1 in MEM_WAIT.
REQ-016 mem_stall SHALL be mem_req and not mem_ready; while mem_stall, stall_pc, stall_ifid, hold_idex, hold_exmem SHALL be 1 and all flush_* 0.
REQ-017 RUN with mem_stall SHALL go to MEM_WAIT; MEM_WAIT with mem_ready SHALL return to RUN; a mem op with mem_ready in the same cycle SHALL incur zero stall.
REQ-018 branch_taken with no mem_stall SHALL assert flush_ifid and flush_idex for that cycle, with no stall.
REQ-019 load_use SHALL be idex_valid, idex_opcode==LOAD_OP, ifid_valid, and idex_ra equal to ifid_ra or ifid_rb.
REQ-020 load_use with no mem_stall and no branch_taken SHALL assert stall_pc, stall_ifid, flush_idex for exactly that cycle (one bubble).
REQ-021 Priority SHALL be mem_stall > branch_taken > load_use; lower-priority events are ignored in that cycle and re-evaluated next cycle from held pipeline contents.
REQ-022 branch_taken during MEM_WAIT SHALL take effect in the cycle mem_ready is seen.
REQ-023 stall_cnt SHALL increment by 1 each cycle stall_pc is 1 and saturate at 8'hFF.

Reset
REQ-024 While reset is 1: state=RUN, stall_cnt=0, mem_err=0, wait counter=0 at the edge; combinational outputs SHALL be flush_ifid/flush_idex/flush_exmem=1, all stalls/holds=0, mem_req=0.
REQ-025 Reset asserted during MEM_WAIT SHALL abandon the access; first cycle after reset SHALL be RUN.

Configuration
REQ-026 With macro PIPECTRL_MEM_TIMEOUT_EN defined: a 4-bit wait counter clears on MEM_WAIT entry and increments each MEM_WAIT cycle without mem_ready.
REQ-027 With PIPECTRL_MEM_TIMEOUT_EN, when the counter equals TIMEOUT without mem_ready: flush_exmem=1, all stalls/holds=0, mem_err set (sticky until reset), next state RUN.
REQ-028 Without PIPECTRL_MEM_TIMEOUT_EN: no wait counter, MEM_WAIT persists until mem_ready, mem_err constant 0.

Verification
REQ-029 exmem op=4'hC valid, mem_ready low 3 cycles then high -> stalls/holds high 3 cycles, state 01 then 00, stall_cnt=3.
REQ-030 idex op=4'hC ra=2, ifid rb=2 valid -> one cycle stall_pc=stall_ifid=flush_idex=1; ifid ra/rb=1 -> no stall.
REQ-031 load_use and branch_taken same cycle -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-032 branch_taken during MEM_WAIT -> flushes 0 until mem_ready cycle, then flush_ifid=flush_idex=1.
REQ-033 TIMEOUT=4, macro on, mem_ready held 0 -> flush_exmem=1 on 4th wait cycle, mem_err=1, state 00; macro off -> stays 01.
REQ-034 300 stall cycles -> stall_cnt=8'hFF; reset pulse mid-MEM_WAIT -> state 00, stall_cnt 0, flushes 1 during reset.
